// File: rtl/dp_ram_pkg.sv
// ============================================================================
// Module   : dp_ram_pkg
// Brief    : Shared constants, FSM encoding and lane-count helper for dp_ram_be
// Revision : 1.0
// ============================================================================
`default_nettype none

package dp_ram_pkg;

   localparam int RDW_READ_FIRST  = 0;
   localparam int RDW_WRITE_FIRST = 1;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } ram_state_t;

   function automatic int num_be(input int data_bits, input int byte_w);
      return data_bits / byte_w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dp_ram_port.sv
// ============================================================================
// Module   : dp_ram_port
// Brief    : Per-port read-data select, optional output register, valid pipe
// Revision : 1.0
// ============================================================================
`default_nettype none

module dp_ram_port
   import dp_ram_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int RDW_MODE  = RDW_READ_FIRST,
   parameter int OUT_REG   = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 acc,
   input  logic                 wr,
   input  logic [DATA_BITS-1:0] old_word,
   input  logic [DATA_BITS-1:0] new_word,
   output logic [DATA_BITS-1:0] dout,
   output logic                 vld
);

   logic [DATA_BITS-1:0] sel_word;
   logic [DATA_BITS-1:0] rd_q;
   logic                 vld_q;

   // Only a port's own write can expose the merged word; cross-port reads see old data.
   assign sel_word = ((RDW_MODE == RDW_WRITE_FIRST) && wr) ? new_word : old_word;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q  <= '0;
         vld_q <= 1'b0;
      end else begin
         vld_q <= acc;
         if (acc) begin
            rd_q <= sel_word;
         end
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [DATA_BITS-1:0] rd_q2;
         logic                 vld_q2;

         always_ff @(posedge clk) begin
            if (rst) begin
               rd_q2  <= '0;
               vld_q2 <= 1'b0;
            end else begin
               vld_q2 <= vld_q;
               if (vld_q) begin
                  rd_q2 <= rd_q;
               end
            end
         end

         assign dout = rd_q2;
         assign vld  = vld_q2;
      end else begin : g_no_out_reg
         assign dout = rd_q;
         assign vld  = vld_q;
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/dp_ram_be.sv
// ============================================================================
// Module   : dp_ram_be
// Brief    : True dual-port byte-enable RAM with reset clear and collision flag
// Revision : 1.0
// ============================================================================
`default_nettype none

module dp_ram_be
   import dp_ram_pkg::*;
#(
   parameter int                       ADDR_SIZE  = 6,
   parameter int                       DATA_BITS  = 8,
   parameter int                       NO_OF_ADDR = 64,
   parameter int                       BYTE_W     = 8,
   parameter int                       RDW_MODE   = RDW_READ_FIRST,
   parameter int                       OUT_REG    = 0,
   parameter logic [DATA_BITS-1:0]     INIT_VAL   = '0
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     en_a,
   input  logic                                     we_a,
   input  logic [num_be(DATA_BITS, BYTE_W)-1:0]     be_a,
   input  logic [ADDR_SIZE-1:0]                     addr_a,
   input  logic [DATA_BITS-1:0]                     din_a,
   output logic [DATA_BITS-1:0]                     dout_a,
   output logic                                     vld_a,
   input  logic                                     en_b,
   input  logic                                     we_b,
   input  logic [num_be(DATA_BITS, BYTE_W)-1:0]     be_b,
   input  logic [ADDR_SIZE-1:0]                     addr_b,
   input  logic [DATA_BITS-1:0]                     din_b,
   output logic [DATA_BITS-1:0]                     dout_b,
   output logic                                     vld_b,
   output logic                                     ready,
   output logic                                     coll
);

   localparam int                   NUM_BE    = num_be(DATA_BITS, BYTE_W);
   localparam logic [ADDR_SIZE:0]   DEPTH     = (ADDR_SIZE+1)'(NO_OF_ADDR);
   localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(NO_OF_ADDR - 1);

   logic [DATA_BITS-1:0] mem [NO_OF_ADDR];

   ram_state_t           state;
   ram_state_t           state_nxt;
   logic [ADDR_SIZE-1:0] clr_cnt;

   logic                 acc_a, acc_b;
   logic                 in_a, in_b;
   logic                 wr_a, wr_b;
   logic [DATA_BITS-1:0] old_a, old_b;
   logic [DATA_BITS-1:0] fin_a, fin_b;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CLEAR;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if ((state == CLEAR) && (clr_cnt == LAST_ADDR)) begin
         state_nxt = RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clr_cnt <= '0;
      end else if (state == CLEAR) begin
         clr_cnt <= clr_cnt + 1'b1;
      end
   end

   assign ready = (state == RUN);

   assign acc_a = en_a & ready;
   assign acc_b = en_b & ready;
   assign in_a  = ({1'b0, addr_a} < DEPTH);
   assign in_b  = ({1'b0, addr_b} < DEPTH);
   assign wr_a  = acc_a & we_a & in_a;
   assign wr_b  = acc_b & we_b & in_b;
   assign old_a = in_a ? mem[addr_a] : '0;
   assign old_b = in_b ? mem[addr_b] : '0;

   // Final word at each address after both ports; A overrides B on shared lanes.
   always_comb begin
      fin_a = old_a;
      fin_b = old_b;
      for (int i = 0; i < NUM_BE; i++) begin
         if (wr_b && be_b[i] && (addr_b == addr_a)) begin
            fin_a[i*BYTE_W +: BYTE_W] = din_b[i*BYTE_W +: BYTE_W];
         end
         if (wr_a && be_a[i]) begin
            fin_a[i*BYTE_W +: BYTE_W] = din_a[i*BYTE_W +: BYTE_W];
         end
         if (wr_b && be_b[i]) begin
            fin_b[i*BYTE_W +: BYTE_W] = din_b[i*BYTE_W +: BYTE_W];
         end
         if (wr_a && be_a[i] && (addr_a == addr_b)) begin
            fin_b[i*BYTE_W +: BYTE_W] = din_a[i*BYTE_W +: BYTE_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == CLEAR) begin
            mem[clr_cnt] <= INIT_VAL;
         end else begin
            if (wr_a) begin
               mem[addr_a] <= fin_a;
            end
            if (wr_b) begin
               mem[addr_b] <= fin_b;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         coll <= 1'b0;
      end else begin
         coll <= wr_a & wr_b & (addr_a == addr_b) & (|(be_a & be_b));
      end
   end

   dp_ram_port #(
      .DATA_BITS (DATA_BITS),
      .RDW_MODE  (RDW_MODE),
      .OUT_REG   (OUT_REG)
   ) u_port_a (
      .clk      (clk),
      .rst      (rst),
      .acc      (acc_a),
      .wr       (wr_a),
      .old_word (old_a),
      .new_word (fin_a),
      .dout     (dout_a),
      .vld      (vld_a)
   );

   dp_ram_port #(
      .DATA_BITS (DATA_BITS),
      .RDW_MODE  (RDW_MODE),
      .OUT_REG   (OUT_REG)
   ) u_port_b (
      .clk      (clk),
      .rst      (rst),
      .acc      (acc_b),
      .wr       (wr_b),
      .old_word (old_b),
      .new_word (fin_b),
      .dout     (dout_b),
      .vld      (vld_b)
   );

endmodule

`default_nettype wire

// File: tb/tb_dp_ram_be.sv
// ============================================================================
// Module   : tb_dp_ram_be
// Brief    : Scoreboard bench driving two dp_ram_be configurations in lockstep
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dp_ram_be;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        en_a = 1'b0, we_a = 1'b0, en_b = 1'b0, we_b = 1'b0;
   logic [1:0]  be_a = '0, be_b = '0;
   logic [5:0]  addr_a = '0, addr_b = '0;
   logic [15:0] din_a = '0, din_b = '0;

   logic [15:0] dout_a0, dout_b0, dout_a1, dout_b1;
   logic        vld_a0, vld_b0, vld_a1, vld_b1;
   logic        ready0, ready1, coll0, coll1;

   // DUT0: 64 words, read-first, no output register, clear to 0
   dp_ram_be #(
      .ADDR_SIZE(6), .DATA_BITS(16), .NO_OF_ADDR(64), .BYTE_W(8),
      .RDW_MODE(0), .OUT_REG(0), .INIT_VAL(16'h0000)
   ) u_dut0 (
      .clk(clk), .rst(rst),
      .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
      .dout_a(dout_a0), .vld_a(vld_a0),
      .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
      .dout_b(dout_b0), .vld_b(vld_b0),
      .ready(ready0), .coll(coll0)
   );

   // DUT1: 60 words (top 4 addresses out of range), write-first, output register
   dp_ram_be #(
      .ADDR_SIZE(6), .DATA_BITS(16), .NO_OF_ADDR(60), .BYTE_W(8),
      .RDW_MODE(1), .OUT_REG(1), .INIT_VAL(16'h5A5A)
   ) u_dut1 (
      .clk(clk), .rst(rst),
      .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
      .dout_a(dout_a1), .vld_a(vld_a1),
      .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
      .dout_b(dout_b1), .vld_b(vld_b1),
      .ready(ready1), .coll(coll1)
   );

   typedef struct {
      int          due;
      logic [15:0] data;
   } rd_t;

   typedef struct {
      logic coll;
      logic rdy;
   } cyc_t;

   int          n_words [2] = '{64, 60};
   int          rdw     [2] = '{0, 1};
   int          oreg    [2] = '{0, 1};
   logic [15:0] init_w  [2] = '{16'h0000, 16'h5A5A};

   logic [15:0] mm [2][64];
   int          cnt [2];
   bit          run [2];

   rd_t         rq [4][$];
   cyc_t        cq [2][$];
   logic [15:0] last_dout [4] = '{16'h0, 16'h0, 16'h0, 16'h0};

   int cyc = 0;
   int vectors = 0;
   int miscompares = 0;
   bit started = 1'b0;

   // One clock of stimulus; the reference model is updated for the edge that follows.
   task automatic step(input logic r,
                       input logic ea, input logic wa, input logic [1:0] ba,
                       input logic [5:0] aa, input logic [15:0] da,
                       input logic eb, input logic wb, input logic [1:0] bb,
                       input logic [5:0] ab, input logic [15:0] db);
      @(negedge clk);
      rst = r;  en_a = ea; we_a = wa; be_a = ba; addr_a = aa; din_a = da;
      en_b = eb; we_b = wb; be_b = bb; addr_b = ab; din_b = db;
      started = 1'b1;
      for (int d = 0; d < 2; d++) begin
         cyc_t        c;
         bit          ina, inb, wra, wrb;
         logic [15:0] olda, oldb, ra, rb;
         c.coll = 1'b0;
         if (r) begin
            rq[2*d].delete();
            rq[2*d+1].delete();
            cnt[d] = 0;
            run[d] = 1'b0;
         end else if (!run[d]) begin
            mm[d][cnt[d]] = init_w[d];
            cnt[d]++;
            if (cnt[d] == n_words[d]) run[d] = 1'b1;
         end else begin
            ina  = int'(aa) < n_words[d];
            inb  = int'(ab) < n_words[d];
            olda = ina ? mm[d][aa] : 16'h0;
            oldb = inb ? mm[d][ab] : 16'h0;
            wra  = ea && wa && ina;
            wrb  = eb && wb && inb;
            for (int l = 0; l < 2; l++)
               if (wrb && bb[l]) mm[d][ab][8*l +: 8] = db[8*l +: 8];
            for (int l = 0; l < 2; l++)
               if (wra && ba[l]) mm[d][aa][8*l +: 8] = da[8*l +: 8];
            c.coll = wra && wrb && (aa == ab) && ((ba & bb) != 2'b00);
            ra = (wra && rdw[d] == 1) ? mm[d][aa] : olda;
            rb = (wrb && rdw[d] == 1) ? mm[d][ab] : oldb;
            if (ea) rq[2*d].push_back('{cyc + 1 + oreg[d], ra});
            if (eb) rq[2*d+1].push_back('{cyc + 1 + oreg[d], rb});
         end
         c.rdy = run[d];
         cq[d].push_back(c);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 1'b0, 2'b00, 6'h0, 16'h0, 1'b0, 1'b0, 2'b00, 6'h0, 16'h0);
   endtask

   task automatic rand_step(input logic r);
      logic [5:0] aa, ab;
      aa = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
      ab = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
      step(r, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           aa, 16'($urandom),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           ab, 16'($urandom));
   endtask

   task automatic sweep();
      for (int a = 0; a < 64; a++)
         step(1'b0, 1'b1, 1'b0, 2'b00, 6'(a), 16'h0, 1'b1, 1'b0, 2'b00, 6'(63 - a), 16'h0);
   endtask

   task automatic chk_port(input int q, input logic v, input logic [15:0] dt, input string nm);
      rd_t e;
      while (rq[q].size() > 0 && rq[q][0].due < cyc) begin
         e = rq[q].pop_front();
         vectors++;
         miscompares++;
         $display("FAIL %s missed: expected data %h due cycle %0d, now %0d", nm, e.data, e.due, cyc);
      end
      vectors++;
      if (rst) begin
         last_dout[q] = 16'h0;
         if (v !== 1'b0 || dt !== 16'h0) begin
            miscompares++;
            $display("FAIL %s reset: vld=%b dout=%h, required vld=0 dout=0000", nm, v, dt);
         end
      end else if (rq[q].size() > 0 && rq[q][0].due == cyc) begin
         e = rq[q].pop_front();
         last_dout[q] = e.data;
         if (v !== 1'b1 || dt !== e.data) begin
            miscompares++;
            $display("FAIL %s read @%0d: vld=%b dout=%h, required vld=1 dout=%h", nm, cyc, v, dt, e.data);
         end
      end else if (v !== 1'b0 || dt !== last_dout[q]) begin
         miscompares++;
         $display("FAIL %s idle @%0d: vld=%b dout=%h, required vld=0 dout=%h", nm, cyc, v, dt, last_dout[q]);
      end
   endtask

   task automatic chk_cyc(input int d, input logic cl, input logic rd, input string nm);
      cyc_t c;
      if (cq[d].size() == 0) return;
      c = cq[d].pop_front();
      vectors += 2;
      if (cl !== c.coll) begin
         miscompares++;
         $display("FAIL %s coll @%0d: got %b required %b", nm, cyc, cl, c.coll);
      end
      if (rd !== c.rdy) begin
         miscompares++;
         $display("FAIL %s ready @%0d: got %b required %b", nm, cyc, rd, c.rdy);
      end
   endtask

   initial begin : monitor
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (started) begin
            chk_port(0, vld_a0, dout_a0, "dut0_a");
            chk_port(1, vld_b0, dout_b0, "dut0_b");
            chk_port(2, vld_a1, dout_a1, "dut1_a");
            chk_port(3, vld_b1, dout_b1, "dut1_b");
            chk_cyc(0, coll0, ready0, "dut0");
            chk_cyc(1, coll1, ready1, "dut1");
         end
      end
   end

   initial begin : stimulus
      step(1'b1, 1'b0, 1'b0, 2'b00, 6'h0, 16'h0, 1'b0, 1'b0, 2'b00, 6'h0, 16'h0);
      idle(64);
      step(1'b0, 1'b1, 1'b0, 2'b00, 6'h3F, 16'h0, 1'b1, 1'b0, 2'b00, 6'h3F, 16'h0);
      // Dual write then cross-port read-back
      step(1'b0, 1'b1, 1'b1, 2'b11, 6'h01, 16'h0033, 1'b1, 1'b1, 2'b11, 6'h02, 16'h0044);
      step(1'b0, 1'b0, 1'b0, 2'b00, 6'h00, 16'h0, 1'b1, 1'b0, 2'b00, 6'h01, 16'h0);
      // Partial-lane write with concurrent cross-port read of the same word
      step(1'b0, 1'b1, 1'b1, 2'b11, 6'h05, 16'hAAAA, 1'b0, 1'b0, 2'b00, 6'h00, 16'h0);
      step(1'b0, 1'b1, 1'b1, 2'b01, 6'h05, 16'h1234, 1'b1, 1'b0, 2'b00, 6'h05, 16'h0);
      // Write/write on one address, with and without lane overlap
      step(1'b0, 1'b1, 1'b1, 2'b11, 6'h07, 16'h1111, 1'b1, 1'b1, 2'b10, 6'h07, 16'h2222);
      step(1'b0, 1'b1, 1'b0, 2'b00, 6'h07, 16'h0, 1'b0, 1'b0, 2'b00, 6'h00, 16'h0);
      step(1'b0, 1'b1, 1'b1, 2'b01, 6'h07, 16'h1111, 1'b1, 1'b1, 2'b10, 6'h07, 16'h2222);
      step(1'b0, 1'b1, 1'b0, 2'b00, 6'h07, 16'h0, 1'b0, 1'b0, 2'b00, 6'h00, 16'h0);
      // Back-to-back streaming reads, B crossing the out-of-range boundary
      step(1'b0, 1'b1, 1'b1, 2'b11, 6'h03, 16'h0055, 1'b0, 1'b0, 2'b00, 6'h00, 16'h0);
      for (int i = 0; i < 8; i++)
         step(1'b0, 1'b1, 1'b0, 2'b00, 6'(3 + i), 16'h0, 1'b1, 1'b0, 2'b00, 6'(56 + i), 16'h0);
      // Writes to out-of-range addresses must be dropped
      step(1'b0, 1'b1, 1'b1, 2'b11, 6'h3E, 16'hBEEF, 1'b1, 1'b1, 2'b11, 6'h3D, 16'hCAFE);
      step(1'b0, 1'b1, 1'b0, 2'b00, 6'h3E, 16'h0, 1'b1, 1'b0, 2'b00, 6'h3D, 16'h0);
      idle(3);
      repeat (1500) rand_step(1'b0);
      // Reset mid-clear with traffic that must be ignored
      idle(2);
      step(1'b1, 1'b0, 1'b0, 2'b00, 6'h0, 16'h0, 1'b0, 1'b0, 2'b00, 6'h0, 16'h0);
      repeat (20) rand_step(1'b0);
      step(1'b1, 1'b0, 1'b0, 2'b00, 6'h0, 16'h0, 1'b0, 1'b0, 2'b00, 6'h0, 16'h0);
      repeat (64) rand_step(1'b0);
      sweep();
      repeat (300) rand_step(1'b0);
      // Reset while running must restore the init pattern everywhere
      idle(2);
      step(1'b1, 1'b0, 1'b0, 2'b00, 6'h0, 16'h0, 1'b0, 1'b0, 2'b00, 6'h0, 16'h0);
      idle(64);
      sweep();
      idle(4);
      for (int q = 0; q < 4; q++) begin
         vectors++;
         if (rq[q].size() != 0) begin
            miscompares++;
            $display("FAIL drain q%0d: %0d reads outstanding, required 0", q, rq[q].size());
         end
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
